// File: rtl/ext_pkg.sv
// Shared encodings and alignment helper for the load-data extension path.
package ext_pkg;

    localparam logic [1:0] SZ_BYTE  = 2'd0;
    localparam logic [1:0] SZ_HALF  = 2'd1;
    localparam logic [1:0] SZ_WORD  = 2'd2;
    localparam logic [1:0] SZ_DWORD = 2'd3;

    // Offset is widened to 3 bits so one helper serves both 32- and 64-bit words.
    function automatic logic is_aligned(input logic [1:0] size, input logic [2:0] off);
        logic ok;
        case (size)
            SZ_BYTE: ok = 1'b1;
            SZ_HALF: ok = (off[0] == 1'b0);
            SZ_WORD: ok = (off[1:0] == 2'b00);
            default: ok = (off == 3'b000);
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/lane_extract.sv
// Combinational lane select plus sign/zero extension of a raw memory read word.
module lane_extract #(
    parameter int DATA_WIDTH = 32,
    parameter int OFF_W      = $clog2(DATA_WIDTH/8),
    parameter bit BIG_ENDIAN = 1'b0
) (
    input  logic [DATA_WIDTH-1:0] data,
    input  logic [OFF_W-1:0]      off,
    input  logic [1:0]            size,
    input  logic                  sign_ext,
    output logic [DATA_WIDTH-1:0] ext_data
);

    localparam logic [7:0] DW8    = 8'(DATA_WIDTH);
    localparam logic [7:0] NB_MAX = 8'(DATA_WIDTH/8);

    logic [7:0]            nbytes;
    logic [7:0]            base;
    logic [7:0]            bits;
    logic [7:0]            shamt;
    logic [DATA_WIDTH-1:0] shifted;
    logic [DATA_WIDTH-1:0] mask;
    logic                  fill;

    always_comb begin
        nbytes  = 8'd1 << size;
        base    = 8'(off) & ~(nbytes - 8'd1);
        bits    = nbytes << 3;
        // Big-endian places byte 0 at the top, so the field is counted down from the MSB.
        shamt   = BIG_ENDIAN ? (DW8 - ((base + nbytes) << 3)) : (base << 3);
        shifted = data >> shamt;
        mask    = {DATA_WIDTH{1'b1}} >> (DW8 - bits);
        fill    = sign_ext & (|(shifted & mask & ~(mask >> 1)));
        ext_data = fill ? (shifted | ~mask) : (shifted & mask);
        if (nbytes > NB_MAX) begin
            ext_data = '0;
        end
    end

endmodule

// File: rtl/load_extender.sv
// MEM/WB load alignment/extension register with stall/flush control and misalignment counter.
module load_extender
    import ext_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int OFF_W      = $clog2(DATA_WIDTH/8),
    parameter int RD_W       = 5,
    parameter bit BIG_ENDIAN = 1'b0,
    parameter int CNT_W      = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [OFF_W-1:0]      in_off,
    input  logic [1:0]            in_size,
    input  logic                  in_signed,
    input  logic [RD_W-1:0]       in_rd,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [RD_W-1:0]       out_rd,
    output logic                  out_misaligned,
    output logic [CNT_W-1:0]      misalign_cnt
);

    logic [DATA_WIDTH-1:0] ext_data;
    logic                  bad_acc;

    logic                  vld_p1;
    logic                  mis_p1;
    logic [DATA_WIDTH-1:0] data_p1;
    logic [RD_W-1:0]       rd_p1;
    logic [CNT_W-1:0]      cnt_p1;

    lane_extract #(
        .DATA_WIDTH (DATA_WIDTH),
        .OFF_W      (OFF_W),
        .BIG_ENDIAN (BIG_ENDIAN)
    ) u_lane (
        .data     (in_data),
        .off      (in_off),
        .size     (in_size),
        .sign_ext (in_signed),
        .ext_data (ext_data)
    );

    // A dword request on a 32-bit datapath is treated like a misaligned access.
    assign bad_acc = ((in_size == SZ_DWORD) && (DATA_WIDTH == 32)) ||
                     !is_aligned(in_size, 3'(in_off));

    // Stage p0 -> p1: the only register; flush dominates stall and valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1  <= 1'b0;
            mis_p1  <= 1'b0;
            data_p1 <= '0;
            rd_p1   <= '0;
            cnt_p1  <= '0;
        end else if (flush) begin
            vld_p1 <= 1'b0;
            mis_p1 <= 1'b0;
        end else if (!stall) begin
            vld_p1 <= in_valid;
            mis_p1 <= in_valid & bad_acc;
            if (in_valid) begin
                data_p1 <= bad_acc ? '0 : ext_data;
                rd_p1   <= in_rd;
                if (bad_acc && (cnt_p1 != {CNT_W{1'b1}})) begin
                    cnt_p1 <= cnt_p1 + CNT_W'(1);
                end
            end
        end
    end

    assign out_valid      = vld_p1;
    assign out_misaligned = mis_p1;
    assign out_data       = data_p1;
    assign out_rd         = rd_p1;
    assign misalign_cnt   = cnt_p1;

endmodule

// File: tb/tb_load_extender.sv
// Scoreboard bench: a 32-bit little-endian unit (2-bit counter) and a 64-bit big-endian unit share stimulus.
module tb_load_extender;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_signed = 1'b0;
    logic [63:0] in_data = '0;
    logic [2:0]  in_off = '0;
    logic [1:0]  in_size = '0;
    logic [4:0]  in_rd = '0;

    logic        a_valid, a_mis;
    logic [31:0] a_data;
    logic [4:0]  a_rd;
    logic [1:0]  a_cnt;
    logic        b_valid, b_mis;
    logic [63:0] b_data;
    logic [4:0]  b_rd;
    logic [7:0]  b_cnt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        vld;
        logic        mis;
        logic [63:0] data;
        logic [4:0]  rd;
        int          cnt;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    exp_t sa = '{vld: 1'b0, mis: 1'b0, data: 64'd0, rd: 5'd0, cnt: 0};
    exp_t sb = '{vld: 1'b0, mis: 1'b0, data: 64'd0, rd: 5'd0, cnt: 0};

    load_extender #(.DATA_WIDTH(32), .RD_W(5), .BIG_ENDIAN(1'b0), .CNT_W(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .in_valid(in_valid),
        .in_data(in_data[31:0]), .in_off(in_off[1:0]), .in_size(in_size), .in_signed(in_signed),
        .in_rd(in_rd), .out_valid(a_valid), .out_data(a_data), .out_rd(a_rd),
        .out_misaligned(a_mis), .misalign_cnt(a_cnt)
    );

    load_extender #(.DATA_WIDTH(64), .RD_W(5), .BIG_ENDIAN(1'b1), .CNT_W(8)) dut_b (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .in_valid(in_valid),
        .in_data(in_data), .in_off(in_off), .in_size(in_size), .in_signed(in_signed),
        .in_rd(in_rd), .out_valid(b_valid), .out_data(b_data), .out_rd(b_rd),
        .out_misaligned(b_mis), .misalign_cnt(b_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Byte-array reference: gather n bytes from the addressed lanes, then extend.
    function automatic void ref_model(input logic [63:0] d, input int width, input bit be,
                                      input int off, input int size, input bit sg,
                                      output bit legal, output logic [63:0] val);
        int n;
        logic [7:0]  bytes [8];
        logic [63:0] v;
        n = 1 << size;
        legal = (n * 8 <= width) && (off % n == 0);
        val = '0;
        if (!legal) return;
        for (int k = 0; k < width / 8; k++)
            bytes[k] = be ? d[width-1-8*k -: 8] : d[8*k +: 8];
        v = '0;
        for (int i = 0; i < n; i++) begin
            if (be) v = v | ({56'd0, bytes[off+i]} << (8 * (n - 1 - i)));
            else    v = v | ({56'd0, bytes[off+i]} << (8 * i));
        end
        if (sg && v[8*n-1])
            for (int b = 8 * n; b < width; b++) v[b] = 1'b1;
        val = v;
    endfunction

    function automatic exp_t advance(exp_t cur, int width, bit be, int cmax);
        exp_t        n;
        bit          legal;
        logic [63:0] v;
        n = cur;
        if (flush) begin
            n.vld = 1'b0;
            n.mis = 1'b0;
        end else if (!stall) begin
            if (!in_valid) begin
                n.vld = 1'b0;
                n.mis = 1'b0;
            end else begin
                ref_model(width == 32 ? {32'd0, in_data[31:0]} : in_data, width, be,
                          int'(in_off) % (width / 8), int'(in_size), in_signed, legal, v);
                n.vld  = 1'b1;
                n.mis  = !legal;
                n.data = legal ? v : 64'd0;
                n.rd   = in_rd;
                if (!legal && n.cnt < cmax) n.cnt++;
            end
        end
        return n;
    endfunction

    task automatic drive(input logic v, input logic [63:0] d, input logic [2:0] off,
                         input logic [1:0] sz, input logic sg, input logic [4:0] rd,
                         input logic st, input logic fl);
        @(negedge clk);
        #1;
        in_valid = v; in_data = d; in_off = off; in_size = sz;
        in_signed = sg; in_rd = rd; stall = st; flush = fl;
        sa = advance(sa, 32, 1'b0, 3);
        sb = advance(sb, 64, 1'b1, 255);
        qa.push_back(sa);
        qb.push_back(sb);
    endtask

    task automatic cmp(input string tag, input exp_t e, input logic vld, input logic mis,
                       input logic [63:0] data, input logic [4:0] rd, input int cnt);
        chk({tag, "_valid"}, {63'd0, vld}, {63'd0, e.vld});
        chk({tag, "_misaligned"}, {63'd0, mis}, {63'd0, e.mis});
        chk({tag, "_cnt"}, 64'(cnt), 64'(e.cnt));
        if (e.vld) begin
            chk({tag, "_data"}, data, e.data);
            chk({tag, "_rd"}, {59'd0, rd}, {59'd0, e.rd});
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (qa.size() > 0) begin
            e = qa.pop_front();
            cmp("sb_a", e, a_valid, a_mis, {32'd0, a_data}, a_rd, int'(a_cnt));
        end
        if (qb.size() > 0) begin
            e = qb.pop_front();
            cmp("sb_b", e, b_valid, b_mis, b_data, b_rd, int'(b_cnt));
        end
    end

    task automatic chk_all_zero(input string tag);
        chk({tag, "_a_valid"}, {63'd0, a_valid}, 64'd0);
        chk({tag, "_a_data"}, {32'd0, a_data}, 64'd0);
        chk({tag, "_a_rd"}, {59'd0, a_rd}, 64'd0);
        chk({tag, "_a_mis"}, {63'd0, a_mis}, 64'd0);
        chk({tag, "_a_cnt"}, {62'd0, a_cnt}, 64'd0);
        chk({tag, "_b_valid"}, {63'd0, b_valid}, 64'd0);
        chk({tag, "_b_data"}, b_data, 64'd0);
        chk({tag, "_b_mis"}, {63'd0, b_mis}, 64'd0);
        chk({tag, "_b_cnt"}, {56'd0, b_cnt}, 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset takes effect before any clock edge.
        #1 rst_n = 1'b0;
        #2 chk_all_zero("reset");
        @(negedge clk);
        #1 rst_n = 1'b1;

        drive(1'b1, {32'd0, 32'h1234_80FF}, 3'd1, 2'd0, 1'b1, 5'd3, 1'b0, 1'b0);
        @(posedge clk); #1;
        chk("le_sbyte_data", {32'd0, a_data}, 64'h0000_0000_FFFF_FF80);
        chk("le_sbyte_valid", {63'd0, a_valid}, 64'd1);

        drive(1'b1, {32'h8001_7F02, 32'd0}, 3'd0, 2'd1, 1'b0, 5'd4, 1'b0, 1'b0);
        @(posedge clk); #1;
        chk("be_uhalf_data", b_data, 64'h0000_0000_0000_8001);

        drive(1'b1, {32'h8001_7F02, 32'd0}, 3'd0, 2'd1, 1'b1, 5'd4, 1'b0, 1'b0);
        @(posedge clk); #1;
        chk("be_shalf_data", b_data, 64'hFFFF_FFFF_FFFF_8001);

        drive(1'b1, {$urandom, $urandom}, 3'd2, 2'd2, 1'b1, 5'd9, 1'b0, 1'b0);
        @(posedge clk); #1;
        chk("misw_mis", {63'd0, a_mis}, 64'd1);
        chk("misw_data", {32'd0, a_data}, 64'd0);
        chk("misw_rd", {59'd0, a_rd}, 64'd9);
        chk("misw_cnt", {62'd0, a_cnt}, 64'd1);

        for (int i = 0; i < 3; i++)
            drive(1'b1, {$urandom, $urandom}, 3'(i + 1), 2'(i), 1'b1, 5'(20 + i), 1'b1, 1'b0);
        @(posedge clk); #1;
        chk("stall_rd", {59'd0, a_rd}, 64'd9);
        chk("stall_cnt", {62'd0, a_cnt}, 64'd1);

        drive(1'b1, {$urandom, $urandom}, 3'd1, 2'd1, 1'b0, 5'd7, 1'b1, 1'b1);
        @(posedge clk); #1;
        chk("flush_valid", {63'd0, a_valid}, 64'd0);
        chk("flush_cnt", {62'd0, a_cnt}, 64'd1);

        for (int i = 0; i < 5; i++)
            drive(1'b1, {$urandom, $urandom}, 3'd1, 2'd1, 1'b0, 5'(i), 1'b0, 1'b0);
        @(posedge clk); #1;
        chk("sat_cnt", {62'd0, a_cnt}, 64'd3);

        drive(1'b0, 64'd0, 3'd0, 2'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        @(posedge clk); #1;
        chk("idle_valid", {63'd0, a_valid}, 64'd0);

        for (int i = 0; i < 400; i++)
            drive(1'($urandom_range(3) != 0), {$urandom, $urandom}, 3'($urandom_range(7)),
                  2'($urandom_range(3)), 1'($urandom_range(1)), 5'($urandom_range(31)),
                  1'($urandom_range(6) == 0), 1'($urandom_range(9) == 0));

        drive(1'b1, {$urandom, $urandom}, 3'd0, 2'd0, 1'b1, 5'd12, 1'b0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk_all_zero("async_rst");
        @(posedge clk); #1;
        chk("rst_hold_valid", {63'd0, a_valid}, 64'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        sa = '{vld: 1'b0, mis: 1'b0, data: 64'd0, rd: 5'd0, cnt: 0};
        sb = '{vld: 1'b0, mis: 1'b0, data: 64'd0, rd: 5'd0, cnt: 0};

        drive(1'b1, {32'd0, 32'h0000_00A5}, 3'd0, 2'd0, 1'b0, 5'd17, 1'b0, 1'b0);
        @(posedge clk); #1;
        chk("post_rst_data", {32'd0, a_data}, 64'h0000_0000_0000_00A5);
        chk("post_rst_valid", {63'd0, a_valid}, 64'd1);

        drive(1'b0, 64'd0, 3'd0, 2'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        @(negedge clk); #1;
        chk("queue_drained", 64'(qa.size() + qb.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/load_extender.md
# load_extender

Registered load-data alignment and extension unit for the MEM/WB boundary of the pipeline. It selects a byte, halfword or word lane from the raw memory read word using the low address bits, then sign- or zero-extends it to the full data width. It also flags misaligned accesses and keeps a saturating misalignment count. It generalises the combinational immediate extender to a run-time size and sign mode, selectable endianness, a parametrised data width, and stall/flush pipeline semantics.

## Interface
Parameters:
- DATA_WIDTH, 32, word width in bits; must be 32 or 64.
- OFF_W, $clog2(DATA_WIDTH/8), byte-offset width.
- RD_W, 5, destination-register tag width.
- BIG_ENDIAN, 0, 0 = byte k at data[8k+7:8k]; 1 = byte k at data[DATA_WIDTH-1-8k -: 8].
- CNT_W, 8, misalignment counter width.

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- stall  in  1  hold output register.
- flush  in  1  kill output register contents.
- in_valid  in  1  load result present this cycle.
- in_data  in  DATA_WIDTH  raw memory read word.
- in_off  in  OFF_W  low address bits.
- in_size  in  2  0 byte, 1 half, 2 word, 3 dword (DATA_WIDTH=64 only).
- in_signed  in  1  1 sign-extend, 0 zero-extend.
- in_rd  in  RD_W  destination tag, passed through.
- out_valid  out  1  registered result valid.
- out_data  out  DATA_WIDTH  extended result.
- out_rd  out  RD_W  registered tag.
- out_misaligned  out  1  registered misalign flag.
- misalign_cnt  out  CNT_W  saturating count of captured misaligned loads.

## Operation
- Lane select:
  - byte: lane = in_off.
  - half: lane = in_off[OFF_W-1:1]; alignment requires in_off[0]=0.
  - word: alignment requires in_off[1:0]=0.
  - dword: alignment requires in_off=0.
- Extension: the fill bit is the MSB of the selected field when in_signed=1, else 0. Word at DATA_WIDTH=32 passes through unchanged, regardless of in_signed.
- Illegal size: in_size=3 with DATA_WIDTH=32 counts as misaligned.
- Misaligned or illegal access: out_data=0, out_misaligned=1, out_valid=1. The tag still passes through, because the trap unit consumes it.
- Capture condition: capture = in_valid & ~stall & ~flush.
- misalign_cnt increments on a capture whose access is misaligned or illegal. It saturates at all-ones and never wraps.

## Timing
- Reset: out_valid=0, out_data=0, out_rd=0, out_misaligned=0, misalign_cnt=0, applied immediately on rst_n low, asynchronously.
- Latency: exactly 1 cycle from capture to out_* update.
- The extend logic is purely combinational ahead of the register; there is no other state.
- flush=1: next edge out_valid=0 and out_misaligned=0. out_data and out_rd hold their previous values (don't-care). Flush wins over stall and over in_valid, and the counter does not increment.
- stall=1 with flush=0: all out_* and misalign_cnt hold; the input is ignored and is not counted.
- stall=0, flush=0, in_valid=0: next edge out_valid=0 and out_misaligned=0.
- Reset mid-stream: any registered result is discarded; the first post-reset capture behaves normally.

## Structure
- Shared package `ext_pkg` holds:
  - size encodings SZ_BYTE=2'd0, SZ_HALF=2'd1, SZ_WORD=2'd2, SZ_DWORD=2'd3;
  - a function `is_aligned(size, off)`.
- One sub-module, `lane_extract`: combinational lane select plus sign/zero extend, parametrised by DATA_WIDTH and BIG_ENDIAN.
- The top level holds the output register, the stall/flush control and the counter.

## Test plan
- Signed byte, LE: in_data=32'h1234_80FF, off=1, size=byte, signed=1 -> next cycle out_data=32'hFFFF_FF80, out_valid=1.
- Unsigned half, BE: BIG_ENDIAN=1, in_data=32'h8001_7F02, off=0, size=half, signed=0 -> out_data=32'h0000_8001; same with signed=1 -> 32'hFFFF_8001.
- Misaligned word: off=2, size=word, in_rd=5'd9 -> out_misaligned=1, out_data=0, out_rd=9, misalign_cnt increments 0->1.
- Stall and flush priority:
  - stall held 3 cycles with changing inputs -> outputs and counter frozen;
  - flush+stall+valid together -> out_valid=0 next cycle, counter unchanged.
- Counter saturation: CNT_W=2, 5 captured misaligned loads -> misalign_cnt reads 3 and stays at 3.
- Async reset: assert rst_n low mid-cycle while out_valid=1 -> all outputs 0 before the next clock edge.
